// File: rtl/elevator_call_register_pkg.sv
// Shared constants for the elevator call front-end: request bit positions,
// floor encodings and the production debounce length.
package elevator_pkg;

    localparam int unsigned REQ_UP     = 0;
    localparam int unsigned REQ_DOWN   = 1;
    localparam int unsigned REQ_TO_ONE = 2;
    localparam int unsigned REQ_TO_TWO = 3;

    localparam logic [1:0] FLOOR_1 = 2'd1;
    localparam logic [1:0] FLOOR_2 = 2'd2;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    // Calls already served by the car's current floor; unknown floors serve nothing.
    function automatic logic [3:0] satisfied_mask(input logic [1:0] floor);
        logic [3:0] mask;
        mask = '0;
        case (floor)
            FLOOR_1: begin
                mask[REQ_UP]     = 1'b1;
                mask[REQ_TO_ONE] = 1'b1;
            end
            FLOOR_2: begin
                mask[REQ_DOWN]   = 1'b1;
                mask[REQ_TO_TWO] = 1'b1;
            end
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/elevator_call_register_btn_conditioner.sv
// One push-button channel: 2-FF synchroniser, hold-time debounce and a
// single-cycle pulse on each debounced rising edge.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_1   <= raw;
            sync_2   <= sync_1;
            stable_d <= stable;
            // Any cycle agreeing with the accepted level restarts the hold window.
            if (sync_2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = stable & ~stable_d;

endmodule

// File: rtl/elevator_call_register.sv
// Two-floor elevator call register: conditions the five buttons, toggles the
// run level and holds pending calls until the controller accepts them.
module elevator_call_register
    import elevator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic       start_stop_btn,
    input  logic [3:0] led_drive,
    input  logic [1:0] floor,
    output logic [3:0] req,
    output logic       start_stop,
    output logic [3:0] call_led
);

    logic [3:0] press;
    logic       run_press;
    logic [3:0] led_drive_d;
    logic [3:0] acc;
    logic [3:0] satisfied;
    logic [3:0] req_next;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_btn (
            .clk  (clk_50mhz),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .press(press[i])
        );
    end

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_run_btn (
        .clk  (clk_50mhz),
        .rst  (rst),
        .raw  (start_stop_btn),
        .press(run_press)
    );

    assign acc       = led_drive & ~led_drive_d;
    assign satisfied = satisfied_mask(floor);

    always_comb begin
        req_next = req;
        for (int unsigned i = 0; i < 4; i++) begin
            // Acceptance outranks a press landing in the same cycle.
            if (acc[i]) begin
                req_next[i] = 1'b0;
            end else if (press[i] && start_stop && !satisfied[i]) begin
                req_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            req         <= '0;
            start_stop  <= 1'b0;
            led_drive_d <= '0;
        end else begin
            req         <= req_next;
            start_stop  <= start_stop ^ run_press;
            led_drive_d <= led_drive;
        end
    end

    assign call_led = req;

endmodule

// File: tb/tb_elevator_call_register.sv
// Scoreboard bench for elevator_call_register with a 4-cycle debounce.
module tb_elevator_call_register;

    logic       clk_50mhz;
    logic       rst;
    logic [3:0] btn_raw;
    logic       start_stop_btn;
    logic [3:0] led_drive;
    logic [1:0] floor;
    logic [3:0] req;
    logic       start_stop;
    logic [3:0] call_led;

    typedef struct {
        string      tag;
        logic [3:0] req;
        logic       run;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks;
    int unsigned errors;

    elevator_call_register #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20)
    ) dut (
        .clk_50mhz     (clk_50mhz),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .start_stop_btn(start_stop_btn),
        .led_drive     (led_drive),
        .floor         (floor),
        .req           (req),
        .start_stop    (start_stop),
        .call_led      (call_led)
    );

    initial clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    task automatic check_eq(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %b want %b", tag, observed, expected);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] exp_req, input logic exp_run);
        exp_t e;
        e.tag = tag;
        e.req = exp_req;
        e.run = exp_run;
        exp_q.push_back(e);
    endtask

    // Pops the oldest expectation and compares it with the live outputs.
    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq({e.tag, "_req"}, {4'b0, req}, {4'b0, e.req});
            check_eq({e.tag, "_led"}, {4'b0, call_led}, {4'b0, e.req});
            check_eq({e.tag, "_run"}, {7'b0, start_stop}, {7'b0, e.run});
        end
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk_50mhz);
    endtask

    task automatic hold_buttons(input logic [3:0] mask, input int unsigned cycles);
        btn_raw = mask;
        wait_cycles(cycles);
        btn_raw = '0;
        wait_cycles(10);
    endtask

    task automatic toggle_run();
        start_stop_btn = 1'b1;
        wait_cycles(10);
        start_stop_btn = 1'b0;
        wait_cycles(10);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b0;
        btn_raw        = 4'hF;
        start_stop_btn = 1'b0;
        led_drive      = '0;
        floor          = 2'd1;

        wait_cycles(3);
        expect_out("reset", 4'b0000, 1'b0);
        check_out();

        rst = 1'b1;
        wait_cycles(15);
        expect_out("held_through_reset_stopped", 4'b0000, 1'b0);
        check_out();
        btn_raw = '0;
        wait_cycles(10);

        // Run toggle: exactly 7 cycles from raw rise.
        start_stop_btn = 1'b1;
        wait_cycles(6);
        expect_out("run_cycle6", 4'b0000, 1'b0);
        check_out();
        wait_cycles(1);
        expect_out("run_cycle7", 4'b0000, 1'b1);
        check_out();
        wait_cycles(3);
        start_stop_btn = 1'b0;
        wait_cycles(10);
        expect_out("run_held_after_release", 4'b0000, 1'b1);
        check_out();
        toggle_run();
        expect_out("run_second_press", 4'b0000, 1'b0);
        check_out();
        toggle_run();
        expect_out("run_third_press", 4'b0000, 1'b1);
        check_out();

        // Bounce on toOne at floor 2: short pulses never latch.
        floor = 2'd2;
        for (int k = 1; k <= 3; k++) begin
            btn_raw[2] = 1'b1;
            wait_cycles(k);
            btn_raw[2] = 1'b0;
            wait_cycles(1);
        end
        wait_cycles(6);
        expect_out("bounce_no_set", 4'b0000, 1'b1);
        check_out();
        btn_raw[2] = 1'b1;
        wait_cycles(6);
        expect_out("bounce_not_early", 4'b0000, 1'b1);
        check_out();
        wait_cycles(4);
        expect_out("bounce_latched", 4'b0100, 1'b1);
        check_out();
        btn_raw[2] = 1'b0;
        wait_cycles(10);
        expect_out("bounce_held", 4'b0100, 1'b1);
        check_out();
        led_drive = 4'b0100;
        wait_cycles(1);
        expect_out("bounce_accepted", 4'b0000, 1'b1);
        check_out();
        led_drive = '0;
        wait_cycles(1);

        // Drop rule.
        floor = 2'd1;
        hold_buttons(4'b0101, 10);
        expect_out("drop_floor1", 4'b0000, 1'b1);
        check_out();
        floor = 2'd2;
        hold_buttons(4'b0101, 10);
        expect_out("latch_floor2", 4'b0101, 1'b1);
        check_out();

        // Accept edges.
        led_drive = 4'b0100;
        wait_cycles(1);
        expect_out("accept_bit2", 4'b0001, 1'b1);
        check_out();
        led_drive = '0;
        wait_cycles(1);
        expect_out("accept_idle", 4'b0001, 1'b1);
        check_out();
        led_drive = 4'b0001;
        wait_cycles(1);
        expect_out("accept_bit0", 4'b0000, 1'b1);
        check_out();
        led_drive = '0;
        wait_cycles(2);

        // Press pulse and accept edge land on the same clock edge.
        btn_raw[0] = 1'b1;
        wait_cycles(6);
        led_drive = 4'b0001;
        wait_cycles(1);
        expect_out("press_vs_accept", 4'b0000, 1'b1);
        check_out();
        wait_cycles(3);
        expect_out("press_vs_accept_after", 4'b0000, 1'b1);
        check_out();
        btn_raw[0] = 1'b0;
        led_drive  = '0;
        wait_cycles(10);

        // Unknown floor value drops nothing.
        floor = 2'd3;
        hold_buttons(4'b0001, 10);
        expect_out("floor3_no_drop", 4'b0001, 1'b1);
        check_out();
        led_drive = 4'b0001;
        wait_cycles(1);
        led_drive = '0;
        wait_cycles(1);

        // Hold while stopped.
        floor = 2'd1;
        hold_buttons(4'b1000, 10);
        expect_out("hold_toTwo", 4'b1000, 1'b1);
        check_out();
        toggle_run();
        expect_out("hold_stopped", 4'b1000, 1'b0);
        check_out();
        hold_buttons(4'b0010, 10);
        expect_out("hold_press_discarded", 4'b1000, 1'b0);
        check_out();

        // Asynchronous reset in the middle of a debounce window.
        btn_raw[1] = 1'b1;
        wait_cycles(4);
        rst = 1'b0;
        #1;
        expect_out("async_reset", 4'b0000, 1'b0);
        check_out();
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(12);
        expect_out("after_reset_held", 4'b0000, 1'b0);
        check_out();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
